// File: rtl/ram_lsu_if.sv
// Core-side request/response handshake plus the RAM port, bundled for ram_lsu.
// The master modport is the requester/RAM side; the slave modport is the LSU.
interface ram_lsu_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_data;
  logic [3:0]            ram_we;
  logic [31:0]           ram_q;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_q,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_data, ram_we
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_q,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/ram_lsu.sv
// Byte/half/word load-store initiator for one byte-enabled RAM port; accesses
// crossing a word boundary are split into two RAM cycles and reassembled.
module ram_lsu #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic        clk_i,
  input  logic        reset_i,
  ram_lsu_if.slave    bus
);
  // state | meaning
  // IDLE  | ready for a request
  // ACC1  | first (or only) RAM access at word
  // ACC2  | second RAM access at word+1 (split)
  // WAIT  | last read data on ram_q; result registered
  // RESP  | response pulse
  typedef enum logic [2:0] {IDLE, ACC1, ACC2, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  split;
  logic [7:0]            mask_base, mask8;
  logic [63:0]           wide;
  logic [31:0]           ld_hi, ld_lo, ld_shift, ld_result;

  assign split     = (size_q == 2'd1 && off_q == 2'd3) || (size_q == 2'd2 && off_q != 2'd0);
  assign mask_base = (size_q == 2'd0) ? 8'h01 : (size_q == 2'd1) ? 8'h03 : 8'h0F;
  assign mask8     = mask_base << off_q;
  assign wide      = {32'b0, wdata_q} << {off_q, 3'b000};

  // In WAIT, ram_q holds the last access: lo if unsplit, hi if split.
  assign ld_hi    = split ? bus.ram_q : 32'b0;
  assign ld_lo    = split ? lo_q : bus.ram_q;
  assign ld_shift = 32'({ld_hi, ld_lo} >> {off_q, 3'b000});

  always_comb begin
    ld_result = ld_shift;
    case (size_q)
      2'd0:    ld_result = {{24{ld_shift[7]  & ~uns_q}}, ld_shift[7:0]};
      2'd1:    ld_result = {{16{ld_shift[15] & ~uns_q}}, ld_shift[15:0]};
      default: ld_result = ld_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    uns_d       = uns_q;
    size_d      = size_q;
    off_d       = off_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus.ram_addr = word_q;
    bus.ram_data = 32'b0;
    bus.ram_we   = 4'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          uns_d   = bus.req_unsigned;
          size_d  = bus.req_size;
          off_d   = bus.req_addr[1:0];
          word_d  = bus.req_addr[ADDR_WIDTH+1:2];
          wdata_d = bus.req_wdata;
          if (bus.req_size == 2'd3) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'b0;
            state_d     = RESP;
          end else begin
            state_d = ACC1;
          end
        end
      end
      ACC1: begin
        bus.ram_addr = word_q;
        if (we_q) begin
          bus.ram_we   = mask8[3:0];
          bus.ram_data = wide[31:0];
        end
        if (split) begin
          state_d = ACC2;
        end else if (we_q) begin
          rsp_rdata_d = 32'b0;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      ACC2: begin
        bus.ram_addr = word_q + 1'b1;
        lo_d         = bus.ram_q;
        if (we_q) begin
          bus.ram_we   = mask8[7:4];
          bus.ram_data = wide[63:32];
          rsp_rdata_d  = 32'b0;
          rsp_err_d    = 1'b0;
          state_d      = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        rsp_rdata_d = ld_result;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      word_q      <= '0;
      wdata_q     <= 32'b0;
      lo_q        <= 32'b0;
      rsp_rdata_q <= 32'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      off_q       <= off_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_ram_lsu.sv
// Directed bench for ram_lsu: a behavioural RAM, a driver that pushes expected
// responses into a scoreboard, and a monitor that checks each rsp_valid pulse.
module tb_ram_lsu;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_lsu_if #(.ADDR_WIDTH(6)) bus();
  ram_lsu #(.ADDR_WIDTH(6)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));

  logic [31:0] mem [64] = '{default: 32'h0};
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.ram_we[i]) mem[bus.ram_addr][8*i +: 8] <= bus.ram_data[8*i +: 8];
    bus.ram_q <= mem[bus.ram_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       nm;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Returns at the negedge of cycle A+1; lat < 0 means no response is expected.
  task automatic issue(input string nm, input logic we, input logic [1:0] size,
                       input logic uns, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
    int guard = 0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: req_ready timeout got 0 expected 1", nm);
    end
    if (lat >= 0) sb.push_back('{exp_rd, exp_err, cyc + lat, nm});
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.rsp_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.nm, "_rdata"}, bus.rsp_rdata, e.rdata);
          chk({e.nm, "_err"}, 32'(bus.rsp_err), 32'(e.err));
          chk({e.nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 8'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_data", bus.ram_data, 32'h0);

    issue("sw08", 1, 2'd2, 0, 8'h08, 32'hDEADBEEF, 32'h0, 0, 2);
    chk("sw08_addr", 32'(bus.ram_addr), 32'd2);
    chk("sw08_we", 32'(bus.ram_we), 32'hF);
    chk("sw08_data", bus.ram_data, 32'hDEADBEEF);
    chk("sw08_ready1", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("sw08_ready2", 32'(bus.req_ready), 32'd0);

    issue("sb05", 1, 2'd0, 0, 8'h05, 32'h000000A5, 32'h0, 0, 2);
    chk("sb05_addr", 32'(bus.ram_addr), 32'd1);
    chk("sb05_we", 32'(bus.ram_we), 32'h2);
    chk("sb05_lane", 32'(bus.ram_data[15:8]), 32'hA5);
    issue("lb05", 0, 2'd0, 0, 8'h05, 32'h0, 32'hFFFFFFA5, 0, 3);
    chk("lb05_we", 32'(bus.ram_we), 32'd0);
    issue("lbu05", 0, 2'd0, 1, 8'h05, 32'h0, 32'h000000A5, 0, 3);

    issue("sw0e", 1, 2'd2, 0, 8'h0E, 32'h11223344, 32'h0, 0, 3);
    chk("sw0e_addr1", 32'(bus.ram_addr), 32'd3);
    chk("sw0e_we1", 32'(bus.ram_we), 32'hC);
    chk("sw0e_data1", bus.ram_data, 32'h33440000);
    @(negedge clk);
    chk("sw0e_addr2", 32'(bus.ram_addr), 32'd4);
    chk("sw0e_we2", 32'(bus.ram_we), 32'h3);
    chk("sw0e_data2", bus.ram_data, 32'h00001122);
    issue("lw0e", 0, 2'd2, 0, 8'h0E, 32'h0, 32'h11223344, 0, 4);

    issue("sw_fc", 1, 2'd2, 0, 8'hFC, 32'hAB000000, 32'h0, 0, 2);
    issue("sw_00", 1, 2'd2, 0, 8'h00, 32'h000000CD, 32'h0, 0, 2);
    issue("lhff", 0, 2'd1, 0, 8'hFF, 32'h0, 32'hFFFFCDAB, 0, 4);
    chk("lhff_addr1", 32'(bus.ram_addr), 32'd63);
    chk("lhff_we1", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    chk("lhff_addr2", 32'(bus.ram_addr), 32'd0);
    issue("lhuff", 0, 2'd1, 1, 8'hFF, 32'h0, 32'h0000CDAB, 0, 4);

    issue("illegal", 1, 2'd3, 0, 8'h10, 32'hFFFFFFFF, 32'h0, 1, 1);
    chk("illegal_we1", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    chk("illegal_we2", 32'(bus.ram_we), 32'd0);

    // Reset lands during ACC1 of a split store: word 3 write occurs, word 4 never.
    issue("sw_rst", 1, 2'd2, 0, 8'h0E, 32'h55667788, 32'h0, 0, -1);
    reset = 1'b1;
    chk("rst_mid_we_acc1", 32'(bus.ram_we), 32'hC);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_we", 32'(bus.ram_we), 32'd0);
    chk("rst_mid_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_we2", 32'(bus.ram_we), 32'd0);
    chk("rst_mid_rsp2", 32'(bus.rsp_valid), 32'd0);
    issue("lw10_after_rst", 0, 2'd2, 0, 8'h10, 32'h0, 32'h00001122, 0, 3);
    issue("lw0c_after_rst", 0, 2'd2, 0, 8'h0C, 32'h0, 32'h77880000, 0, 3);
    issue("lbu0e_after_rst", 0, 2'd0, 1, 8'h0E, 32'h0, 32'h00000088, 0, 3);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d pending responses expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_lsu.md
Name: ram_lsu

Overview:
- Load/store initiator that drives one byte-enabled port of the shared dual-port RAM on behalf of the core.
- Accepts RISC-V style byte, half and word loads and stores at any byte address.
- Generates the word address, byte write-enables and lane-shifted write data for each RAM access.
- Splits accesses that cross a word boundary into two RAM accesses, then reassembles, sign- or zero-extends, and returns the result through a simple request/response handshake.

Parameters:
ADDR_WIDTH, 6, RAM word-address width; byte address is ADDR_WIDTH+2 bits

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when high with req_valid
req_we  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  input  1  zero-extend load (LBU/LHU); ignored otherwise
req_addr  input  ADDR_WIDTH+2  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  load result; 0 for stores/errors
rsp_err  output  1  illegal size
ram_addr  output  ADDR_WIDTH  RAM word address
ram_data  output  32  RAM write data
ram_we  output  4  RAM byte write enables
ram_q  input  32  RAM read data, valid one cycle after ram_addr

Behaviour:
- Reset: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_we=0, ram_addr=0, ram_data=0; req_ready=1 in the first cycle after reset.
- Reset mid-operation: abandons the operation. No further RAM write is issued after the reset cycle. A write already performed stays in the RAM. No response is issued.
- States: IDLE, ACC1, ACC2, WAIT, RESP.
- req_ready = (state==IDLE). Handshake occurs in cycle A; the request fields are latched at that point.
- Transitions:
  - IDLE->RESP if size==3; IDLE->ACC1 otherwise.
  - ACC1->ACC2 if split; otherwise WAIT for a load, RESP for a store.
  - ACC2->WAIT for a load, RESP for a store.
  - WAIT->RESP.
  - RESP->IDLE.
- rsp_valid=1 only in RESP. There is no response backpressure.
- off = addr[1:0]; word = addr[ADDR_WIDTH+1:2].
- split = (size==1 && off==3) || (size==2 && off!=0).
- Address: ACC1 drives word; ACC2 drives (word+1) mod 2^ADDR_WIDTH, so it wraps 2^ADDR_WIDTH-1 -> 0.
- Lane math (64-bit intermediate):
  - mask8 = {1,3,F}[size] << off.
  - wide = {32'b0, wdata} << 8*off.
  - ACC1: ram_we = mask8[3:0], ram_data = wide[31:0].
  - ACC2: ram_we = mask8[7:4], ram_data = wide[63:32].
- Loads drive ram_we=0. ram_we is 0 in IDLE, WAIT and RESP. ram_data is don't-care when ram_we=0.
- Load timing:
  - q of the ACC1 access is captured as lo in the following cycle.
  - q of the ACC2 access is captured as hi in WAIT.
  - hi=0 if not split.
  - Result = ({hi, lo} >> 8*off), truncated to size and sign-extended unless req_unsigned.
  - The result is registered into rsp_rdata on entry to RESP.
- Latency from acceptance cycle A:
  - aligned store: ram write at A+1, rsp at A+2.
  - split store: writes at A+1 and A+2, rsp at A+3.
  - aligned load: addr at A+1, rsp at A+3.
  - split load: addrs at A+1 and A+2, rsp at A+4.
  - illegal: rsp at A+1 with rsp_err=1, rsp_rdata=0, no RAM access.
- rsp_err=0 for legal sizes. rsp_rdata=0 for stores.
- req_valid while busy: ignored until IDLE; the requester holds the request.

Test Plan:
- SW addr 0x08 data 0xDEADBEEF -> A+1: ram_addr=2, ram_we=4'b1111, ram_data=0xDEADBEEF; A+2: rsp_valid=1, rsp_err=0, req_ready low during A+1..A+2.
- SB addr 0x05 data 0x000000A5 -> ram_addr=1, ram_we=4'b0010, ram_data[15:8]=0xA5. Then LB addr 0x05 -> rsp_rdata=0xFFFFFFA5 at A+3; LBU -> 0x000000A5.
- Misaligned SW addr 0x0E data 0x11223344 -> A+1: addr 3, we=1100, data 0x33440000; A+2: addr 4, we=0011, data 0x00001122; rsp at A+3. Then LW 0x0E -> 0x11223344 at A+4.
- Wrap, ADDR_WIDTH=6: words 63=0xAB000000 and 0=0x000000CD; LH addr 0xFF -> addrs 63 then 0, rsp_rdata=0xFFFFCDAB; LHU -> 0x0000CDAB.
- req_size=3 at addr 0x10 -> rsp_valid and rsp_err at A+1, rsp_rdata=0, ram_we stays 0 throughout.
- Split SW at 0x0E with reset asserted in the ACC1 cycle -> word 4 never written (ram_we=0 afterwards), no rsp_valid, req_ready=1 the cycle after reset deasserts. Back-to-back requests then complete in order.
